// File: rtl/arm_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : arm_hazard_fwd_unit
// Purpose  : Pipeline hazard detection with optional operand forwarding.
//            A shift-register scoreboard holds the destination register of
//            every instruction in flight after ID (slot 0 = EXE,
//            slot STAGES-1 = WB). In stall-only mode any pending producer
//            freezes IF/ID; in forwarding mode only a load-use freezes IF/ID
//            and registered forwarding selects travel with the instruction
//            into EXE. Taken branches flush the ID instruction.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            id_*               - decoded fields of the instruction in ID
//            branch_taken       - EXE resolved a taken branch (flush)
//            hazard             - combinational freeze of PC and IF/ID
//            fwd_sel1/fwd_sel2  - registered operand source select for EXE
//            inflight_wb        - per-slot valid & wb_en (debug)
//            stall_count        - saturating count of hazard cycles
//            flush_count        - saturating count of flush cycles
// Revision : 1.0 - initial release
// ============================================================================
module arm_hazard_fwd_unit #(
    parameter int REG_W  = 4,
    parameter int STAGES = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic              id_src1_used,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              branch_taken,
    output logic              hazard,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [STAGES-1:0] inflight_wb,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // Scoreboard slots
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wb_en;
    logic [STAGES-1:0] r_mem_read;
    logic [REG_W-1:0]  r_dest [STAGES];

    // Per-slot source matches; the WB slot is excluded because the register
    // file write is already visible to ID in that cycle.
    logic [STAGES-2:0] w_match1;
    logic [STAGES-2:0] w_match2;
    logic              w_hazard_raw;
    logic              w_issue;
    logic [SEL_W-1:0]  w_sel1_nxt;
    logic [SEL_W-1:0]  w_sel2_nxt;
    logic              w_unused;

    generate
        for (genvar i = 0; i < STAGES - 1; i++) begin : g_match
            assign w_match1[i] = r_valid[i] & r_wb_en[i] & (r_dest[i] == id_src1)
                               & id_src1_used & id_valid;
            assign w_match2[i] = r_valid[i] & r_wb_en[i] & (r_dest[i] == id_src2)
                               & id_two_src & id_valid;
        end
    endgenerate

    generate
        if (FWD_EN != 0) begin : g_fwd
            // Only a load in EXE cannot be forwarded in time.
            assign w_hazard_raw = (w_match1[0] | w_match2[0]) & r_mem_read[0];

            // Descending scan so the youngest (lowest-index) producer wins.
            always_comb begin
                w_sel1_nxt = '0;
                w_sel2_nxt = '0;
                for (int i = STAGES - 2; i >= 0; i--) begin
                    if (w_match1[i]) w_sel1_nxt = SEL_W'(i + 1);
                    if (w_match2[i]) w_sel2_nxt = SEL_W'(i + 1);
                end
            end
        end else begin : g_stall
            assign w_hazard_raw = |(w_match1 | w_match2);
            assign w_sel1_nxt   = '0;
            assign w_sel2_nxt   = '0;
        end
    endgenerate

    // A flush kills the ID instruction, so holding it would be pointless.
    assign hazard  = w_hazard_raw & ~branch_taken;
    assign w_issue = id_valid & ~hazard & ~branch_taken;

    assign inflight_wb = r_valid & r_wb_en;

    // The WB slot's destination and the deeper mem_read bits only ride along
    // the shift register; they never feed a decision.
    assign w_unused = ^{r_mem_read, r_dest[STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_wb_en     <= '0;
            r_mem_read  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dest[k] <= '0;
            end
            fwd_sel1    <= '0;
            fwd_sel2    <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            r_valid    <= {r_valid[STAGES-2:0], w_issue};
            r_wb_en    <= {r_wb_en[STAGES-2:0], id_wb_en};
            r_mem_read <= {r_mem_read[STAGES-2:0], id_mem_read};
            r_dest[0]  <= id_dest;
            for (int k = 1; k < STAGES; k++) begin
                r_dest[k] <= r_dest[k-1];
            end

            // Selects are zero whenever a bubble enters EXE.
            if (w_issue) begin
                fwd_sel1 <= w_sel1_nxt;
                fwd_sel2 <= w_sel2_nxt;
            end else begin
                fwd_sel1 <= '0;
                fwd_sel2 <= '0;
            end

            if (hazard && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_taken && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_hazard_fwd_unit
// Purpose  : Directed self-checking bench. Two instances share the ID
//            stimulus: a stall-only unit with 2-bit counters and a forwarding
//            unit with 16-bit counters. Each step pushes its expectations to
//            a queue; hazard is compared in the drive cycle and the
//            forwarding selects after the next edge when the entry is popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_hazard_fwd_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1;
    logic       id_src1_used;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_wb_en;
    logic       id_mem_read;
    logic [3:0] id_dest;
    logic       branch_taken;

    logic        hz_s, hz_f;
    logic [1:0]  s1_s, s2_s, s1_f, s2_f;
    logic [2:0]  inf_s, inf_f;
    logic [1:0]  sc_s, fc_s;
    logic [15:0] sc_f, fc_f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       fwd;
        logic       haz;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;
    exp_t exp_q[$];

    arm_hazard_fwd_unit #(.REG_W(4), .STAGES(3), .FWD_EN(0), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .hazard(hz_s),
        .fwd_sel1(s1_s), .fwd_sel2(s2_s), .inflight_wb(inf_s),
        .stall_count(sc_s), .flush_count(fc_s)
    );

    arm_hazard_fwd_unit #(.REG_W(4), .STAGES(3), .FWD_EN(1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .branch_taken(branch_taken), .hazard(hz_f),
        .fwd_sel1(s1_f), .fwd_sel2(s2_f), .inflight_wb(inf_f),
        .stall_count(sc_f), .flush_count(fc_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one ID cycle; called at edge+1, returns at next edge+1.
    task automatic step(input logic fwd, input logic v,
                        input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2,
                        input logic we, input logic mr, input logic [3:0] d,
                        input logic bt, input logic eh,
                        input logic [1:0] e1, input logic [1:0] e2);
        exp_t e;
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_two_src   = u2;
        id_wb_en     = we;
        id_mem_read  = mr;
        id_dest      = d;
        branch_taken = bt;
        e.fwd = fwd; e.haz = eh; e.s1 = e1; e.s2 = e2;
        exp_q.push_back(e);
        #1;
        chk(fwd ? "hazard_f" : "hazard_s", {15'd0, fwd ? hz_f : hz_s}, {15'd0, exp_q[0].haz});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(e.fwd ? "fwd_sel1_f" : "fwd_sel1_s", {14'd0, e.fwd ? s1_f : s1_s}, {14'd0, e.s1});
        chk(e.fwd ? "fwd_sel2_f" : "fwd_sel2_s", {14'd0, e.fwd ? s2_f : s2_s}, {14'd0, e.s2});
    endtask

    task automatic idle(input logic fwd);
        step(fwd, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0);
    endtask

    task automatic prod(input logic fwd, input logic [3:0] d, input logic mr);
        step(fwd, 1, 4'd0, 0, 4'd0, 0, 1, mr, d, 0, 0, 2'd0, 2'd0);
    endtask

    task automatic rd(input logic fwd, input logic [3:0] s1, input logic u1,
                      input logic [3:0] s2, input logic u2, input logic eh,
                      input logic [1:0] e1, input logic [1:0] e2);
        step(fwd, 1, s1, u1, s2, u2, 0, 0, 4'd0, 0, eh, e1, e2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_src1 = 0; id_src1_used = 0; id_src2 = 0; id_two_src = 0;
        id_wb_en = 0; id_mem_read = 0; id_dest = 0; branch_taken = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_hazard_s", {15'd0, hz_s}, 16'd0);
        chk("rst_hazard_f", {15'd0, hz_f}, 16'd0);
        chk("rst_sel1_f", {14'd0, s1_f}, 16'd0);
        chk("rst_sel2_f", {14'd0, s2_f}, 16'd0);
        chk("rst_inflight_s", {13'd0, inf_s}, 16'd0);
        chk("rst_inflight_f", {13'd0, inf_f}, 16'd0);
        chk("rst_stall_f", sc_f, 16'd0);
        chk("rst_flush_f", fc_f, 16'd0);
        rst = 1'b0;

        // Stall mode: dependent reader waits STAGES-1 = 2 cycles
        prod(0, 4'd1, 0);
        rd(0, 4'd1, 1, 4'd0, 0, 1, 2'd0, 2'd0);
        rd(0, 4'd1, 1, 4'd0, 0, 1, 2'd0, 2'd0);
        rd(0, 4'd1, 1, 4'd0, 0, 0, 2'd0, 2'd0);
        chk("stall_cnt_2", {14'd0, sc_s}, 16'd2);

        // Stall mode saturation with 2-bit counter
        prod(0, 4'd2, 0);
        rd(0, 4'd2, 1, 4'd0, 0, 1, 2'd0, 2'd0);
        rd(0, 4'd2, 1, 4'd0, 0, 1, 2'd0, 2'd0);
        rd(0, 4'd2, 1, 4'd0, 0, 0, 2'd0, 2'd0);
        prod(0, 4'd3, 0);
        rd(0, 4'd0, 0, 4'd3, 1, 1, 2'd0, 2'd0);
        chk("stall_cnt_sat", {14'd0, sc_s}, 16'd3);
        rd(0, 4'd0, 0, 4'd3, 1, 1, 2'd0, 2'd0);
        rd(0, 4'd0, 0, 4'd3, 1, 0, 2'd0, 2'd0);
        chk("stall_cnt_sat2", {14'd0, sc_s}, 16'd3);

        // Forward mode: select follows producer distance
        do_reset();
        prod(1, 4'd1, 0);
        rd(1, 4'd1, 1, 4'd5, 1, 0, 2'd1, 2'd0);
        rd(1, 4'd1, 1, 4'd0, 0, 0, 2'd2, 2'd0);
        rd(1, 4'd1, 1, 4'd0, 0, 0, 2'd0, 2'd0);
        chk("fwd_no_stall", sc_f, 16'd0);

        // Load-use: one stall then forward from slot 1
        repeat (3) idle(1);
        prod(1, 4'd2, 1);
        rd(1, 4'd0, 1, 4'd2, 1, 1, 2'd0, 2'd0);
        chk("lu_inflight", {13'd0, inf_f}, 16'b010);
        rd(1, 4'd0, 1, 4'd2, 1, 0, 2'd0, 2'd2);
        chk("lu_stall_cnt", sc_f, 16'd1);

        // Youngest producer wins
        repeat (3) idle(1);
        prod(1, 4'd1, 0);
        prod(1, 4'd1, 0);
        rd(1, 4'd1, 1, 4'd0, 0, 0, 2'd1, 2'd0);

        // Store (no write-back) never matches
        repeat (3) idle(1);
        step(1, 1, 4'd0, 0, 4'd0, 0, 0, 0, 4'd1, 0, 0, 2'd0, 2'd0);
        rd(1, 4'd1, 1, 4'd1, 1, 0, 2'd0, 2'd0);

        // Flush outranks load-use stall
        repeat (3) idle(1);
        prod(1, 4'd2, 1);
        step(1, 1, 4'd2, 1, 4'd0, 0, 1, 0, 4'd3, 1, 0, 2'd0, 2'd0);
        chk("flush_inflight", {13'd0, inf_f}, 16'b010);
        chk("flush_cnt", fc_f, 16'd1);
        chk("flush_stall_cnt", sc_f, 16'd1);
        idle(1);

        // Fill all slots, then reset mid-operation
        prod(1, 4'd1, 0);
        prod(1, 4'd1, 0);
        prod(1, 4'd1, 0);
        chk("full_inflight", {13'd0, inf_f}, 16'b111);
        rst = 1'b1;
        id_valid = 1; id_src1 = 4'd1; id_src1_used = 1; id_src2 = 4'd1; id_two_src = 1;
        id_wb_en = 0; id_mem_read = 0; id_dest = 0; branch_taken = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_hazard_s", {15'd0, hz_s}, 16'd0);
        chk("mrst_hazard_f", {15'd0, hz_f}, 16'd0);
        chk("mrst_inflight_f", {13'd0, inf_f}, 16'd0);
        chk("mrst_inflight_s", {13'd0, inf_s}, 16'd0);
        chk("mrst_sel1_f", {14'd0, s1_f}, 16'd0);
        chk("mrst_stall_f", sc_f, 16'd0);
        chk("mrst_flush_f", fc_f, 16'd0);
        chk("mrst_stall_s", {14'd0, sc_s}, 16'd0);
        rd(0, 4'd1, 1, 4'd1, 1, 0, 2'd0, 2'd0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
